baud_gen: RTL and testbench

BAUD_GEN -- requirements
Module: baud_gen

---
 rtl/uart_pkg.sv | 34 +++
 rtl/tick_div.sv | 35 +++
 rtl/baud_gen.sv | 135 +++++++++++++
 tb/tb_baud_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART timing definitions: baud-rate table, divisor rounding and the
// baud generator state encoding.
package uart_pkg;

  localparam int unsigned NUM_RATES          = 8;
  localparam int unsigned FRAME_BITS_DEFAULT = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } bg_state_t;

  // Rate index 0..7 maps to the standard rates 1200..115200 bit/s.
  function automatic int unsigned baud_rate(input int unsigned sel);
    int unsigned rate;
    case (sel)
      0:       rate = 1200;
      1:       rate = 2400;
      2:       rate = 4800;
      3:       rate = 9600;
      4:       rate = 19200;
      5:       rate = 38400;
      6:       rate = 57600;
      default: rate = 115200;
    endcase
    return rate;
  endfunction

  function automatic int unsigned div_round(input int unsigned num,
                                            input int unsigned den);
    return (num + den / 2) / den;
  endfunction

endpackage

// File: rtl/tick_div.sv
// Modulo-N counter: the modulus is loaded on 'load', 'clear' zeroes the count,
// and 'term' flags the last count of each period while enabled.
module tick_div #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         term
);

  logic [W-1:0] modulus;

  assign term = enable && (count == modulus - W'(1));

  // load has priority over clear so a restart always begins from count 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      modulus <= '0;
    end else if (load) begin
      modulus <= load_val;
      count   <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= term ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/baud_gen.sv
// UART baud generator: mid-bit strobe, end-of-bit strobe, oversample tick and
// frame boundary pulses derived from a rate table fixed at elaboration.
module baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 25_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FRAME_BITS = FRAME_BITS_DEFAULT,
  parameter int unsigned DIV_W      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bps_start,
  input  logic [2:0] baud_sel,
  output logic       clk_bps,
  output logic       bit_end,
  output logic       os_tick,
  output logic       frame_done,
  output logic       busy,
  output logic [3:0] bit_idx
);

  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  logic [DIV_W-1:0] div_tab [NUM_RATES];
  logic [DIV_W-1:0] os_tab  [NUM_RATES];

  if (FRAME_BITS < 1 || FRAME_BITS > 16) begin : g_bad_frame
    $error("baud_gen: FRAME_BITS must be 1..16");
  end

  for (genvar i = 0; i < NUM_RATES; i++) begin : g_rate
    localparam int unsigned DIV    = div_round(CLK_HZ, baud_rate(i));
    localparam int unsigned OS_DIV = div_round(DIV, OVERSAMPLE);

    if (64'(DIV) > ((64'd1 << DIV_W) - 64'd1)) begin : g_div_wide
      $error("baud_gen: divisor does not fit in DIV_W bits");
    end
    if (DIV < 2 * OVERSAMPLE) begin : g_div_small
      $error("baud_gen: divisor smaller than 2*OVERSAMPLE");
    end

    assign div_tab[i] = DIV_W'(DIV);
    assign os_tab[i]  = DIV_W'(OS_DIV);
  end

  bg_state_t        state;
  bg_state_t        state_nxt;
  logic             start_load;
  logic             running;
  logic [DIV_W-1:0] bit_mid;
  logic [DIV_W-1:0] bit_cnt;
  logic             bit_term;
  logic [DIV_W-1:0] os_cnt_unused;
  logic             os_term;

  assign start_load = (state == ST_IDLE) && bps_start;
  assign running    = (state == ST_RUN) && bps_start;
  assign busy       = (state == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bps_start)  state_nxt = ST_RUN;
      ST_RUN:  if (!bps_start) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The mid-bit compare point is captured with the divisor so baud_sel is
  // free to change while a frame is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_mid <= '0;
    end else if (start_load) begin
      bit_mid <= div_tab[baud_sel] >> 1;
    end
  end

  tick_div #(.W(DIV_W)) u_bit_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_load),
    .load_val (div_tab[baud_sel]),
    .clear    (!bps_start),
    .enable   (running),
    .count    (bit_cnt),
    .term     (bit_term)
  );

  tick_div #(.W(DIV_W)) u_os_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_load),
    .load_val (os_tab[baud_sel]),
    .clear    (!bps_start || bit_term),
    .enable   (running),
    .count    (os_cnt_unused),
    .term     (os_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= '0;
    end else if (!running) begin
      bit_idx <= '0;
    end else if (bit_term) begin
      bit_idx <= (bit_idx == LAST_BIT) ? 4'd0 : bit_idx + 4'd1;
    end
  end

  // All strobes are registered, so each lands one cycle after its compare hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_bps    <= 1'b0;
      bit_end    <= 1'b0;
      os_tick    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      clk_bps    <= running && (bit_cnt == bit_mid);
      bit_end    <= bit_term;
      os_tick    <= os_term;
      frame_done <= bit_term && (bit_idx == LAST_BIT);
    end
  end

endmodule

// File: tb/tb_baud_gen.sv
// Scoreboard bench for baud_gen: stimulus queues expected pulse times, a
// negedge monitor pops and compares them as the DUT emits pulses.
module tb_baud_gen;

  logic       clk;
  logic       rst_n;
  logic       bps_start;
  logic [2:0] baud_sel;
  logic       clk_bps;
  logic       bit_end;
  logic       os_tick;
  logic       frame_done;
  logic       busy;
  logic [3:0] bit_idx;

  baud_gen #(
    .CLK_HZ     (25_000_000),
    .OVERSAMPLE (16),
    .FRAME_BITS (10),
    .DIV_W      (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bps_start  (bps_start),
    .baud_sel   (baud_sel),
    .clk_bps    (clk_bps),
    .bit_end    (bit_end),
    .os_tick    (os_tick),
    .frame_done (frame_done),
    .busy       (busy),
    .bit_idx    (bit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed round(25e6/rate) and round(DIV/16) for rates 1200..115200.
  int div_ref [8] = '{20833, 10417, 5208, 2604, 1302, 651, 434, 217};
  int os_ref  [8] = '{1302, 651, 326, 163, 81, 41, 27, 14};
  string pname [4] = '{"clk_bps", "bit_end", "frame_done", "os_tick"};

  typedef struct {
    int cyc;
    int idx;
  } ev_t;

  ev_t exp_q [4][$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string what, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", what, act, exp, cyc);
    end
  endtask

  // Expected pulse times for a run whose counters start at 0 in cycle t0 and
  // which is stopped after cycle t_last.
  task automatic pushExpected(input int sel, input int t0, input int t_last);
    int  d  = div_ref[sel];
    int  os = os_ref[sel];
    ev_t e;
    for (int k = 0; t0 + k * d <= t_last; k++) begin
      e.cyc = t0 + d / 2 + 1 + k * d;
      e.idx = k % 10;
      if (e.cyc <= t_last) exp_q[0].push_back(e);
      for (int off = os - 1; off <= d - 1; off += os) begin
        e.cyc = t0 + k * d + off + 1;
        e.idx = -1;
        if (e.cyc <= t_last) exp_q[3].push_back(e);
      end
      e.cyc = t0 + (k + 1) * d;
      e.idx = (k + 1) % 10;
      if (e.cyc <= t_last) begin
        exp_q[1].push_back(e);
        if ((k + 1) % 10 == 0) exp_q[2].push_back(e);
      end
    end
  endtask

  task automatic applyStimulus(input int sel, input int run_len, input int alt_sel,
                               input int alt_at, input bit drop);
    int t0;
    int t_last;
    @(negedge clk);
    baud_sel  = 3'(sel);
    bps_start = 1'b1;
    t0        = cyc + 1;
    t_last    = t0 + run_len - 1;
    pushExpected(sel, t0, t_last);
    while (cyc < t_last) begin
      @(negedge clk);
      if (alt_at >= 0 && cyc == t0 + alt_at) baud_sel = 3'(alt_sel);
    end
    if (drop) bps_start = 1'b0;
  endtask

  task automatic checkDrained(input string tag);
    for (int k = 0; k < 4; k++)
      checkOutput({tag, " ", pname[k], " missing pulses"}, exp_q[k].size(), 0);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " busy"}, int'(busy), 0);
    checkOutput({tag, " bit_idx"}, int'(bit_idx), 0);
    checkOutput({tag, " pulses"}, int'({os_tick, frame_done, bit_end, clk_bps}), 0);
  endtask

  logic [3:0] prev_p = 4'b0;
  logic [3:0] cur_p;
  ev_t        got;

  always @(negedge clk) begin
    cur_p = {os_tick, frame_done, bit_end, clk_bps};
    if (cur_p != 4'b0) begin
      checkOutput("pulse wider than one cycle", int'(cur_p & prev_p), 0);
      checkOutput("clk_bps with bit_end", int'(clk_bps & bit_end), 0);
      if (frame_done) checkOutput("frame_done without bit_end", int'(bit_end), 1);
      for (int k = 0; k < 4; k++) begin
        if (cur_p[k]) begin
          if (exp_q[k].size() == 0) begin
            checkOutput({pname[k], " unexpected pulse"}, 1, 0);
          end else begin
            got = exp_q[k].pop_front();
            checkOutput({pname[k], " cycle"}, cyc, got.cyc);
            if (got.idx >= 0) checkOutput({pname[k], " bit_idx"}, int'(bit_idx), got.idx);
          end
        end
      end
    end
    prev_p = cur_p;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not end, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  int sweep_sel [6] = '{0, 1, 2, 4, 5, 6};

  initial begin
    rst_n     = 1'b0;
    bps_start = 1'b0;
    baud_sel  = 3'd0;
    repeat (3) @(negedge clk);
    checkIdle("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkIdle("idle after reset");

    // 9600: full frame, seamless second frame, baud_sel change ignored,
    // stop while bit 5 of the second frame is in progress.
    applyStimulus(3, 40060, 7, 5000, 1'b1);
    checkOutput("busy before stop", int'(busy), 1);
    checkOutput("bit_idx before stop", int'(bit_idx), 5);
    @(negedge clk);
    checkIdle("after stop");
    checkDrained("9600 run");
    repeat (20) @(negedge clk);

    // Restart at 9600, then a one-clock drop and restart at 115200.
    applyStimulus(3, 1310, 0, -1, 1'b1);
    applyStimulus(7, 4174, 0, -1, 1'b0);
    checkOutput("bit_idx before reset", int'(bit_idx), 9);
    rst_n     = 1'b0;
    bps_start = 1'b0;
    #1;
    checkIdle("async reset");
    @(negedge clk);
    checkDrained("115200 run");
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checkIdle("idle after reset release");

    // Remaining rates: at least one mid-bit strobe each, full bit where cheap.
    foreach (sweep_sel[i]) begin
      applyStimulus(sweep_sel[i],
                    (sweep_sel[i] == 0) ? div_ref[0] / 2 + 3 : div_ref[sweep_sel[i]] + 3,
                    0, -1, 1'b1);
      @(negedge clk);
      checkDrained($sformatf("rate %0d", sweep_sel[i]));
      checkOutput($sformatf("rate %0d busy after stop", sweep_sel[i]), int'(busy), 0);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
